adc_monitor: RTL and testbench
==============================

ADC_MONITOR -- requirements
Module: adc_monitor

Interface
REQ-001 Parameter NTRIP, default 4: consecutive over-threshold samples needed to trip a channel (1..15).
REQ-002 Parameter AVG_LOG2, default 4: moving-average time constant, 2^AVG_LOG2 samples (1..8).
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 reg_we_i  input  1  register write strobe, one cycle per write.
REQ-006 reg_addr_i  input  8  register address.
REQ-007 reg_data_i  input  16  register write data.
REQ-008 reg_data_o  output  16  register read data, combinational from reg_addr_i.
REQ-009 adc_valid_i  input  1  one-cycle pulse: new set of six conversions is stable on adc0_i..adc5_i.
REQ-010 adc0_i..adc5_i  input  12 each  latest unsigned conversion, channels 0..5.
REQ-011 trip_o  output  6  sticky per-channel over-threshold flags.
REQ-012 trip_any_o  output  1  OR of trip_o.

Function
REQ-013 Register map: 0x10-0x15 THR0-5 (RW, bits 11:0); 0x16 EN (RW, bits 5:0, channel trip enable); 0x17 STAT (bits 5:0 trip, bit 8 overrun; write 1 clears, write 0 no effect); 0x18-0x1D AVG0-5 (RO, bits 11:0); unused read bits 0; unmapped addresses read 16'h0000; writes to RO/unmapped addresses ignored.
REQ-014 On adc_valid_i while IDLE, all six inputs are snapshotted in the same cycle and FSM enters RUN with channel index 0.
REQ-015 FSM states: IDLE, RUN; RUN processes channel k in cycle k (k=0..5), returns to IDLE after k=5; no other states.
REQ-016 Processing one channel per cycle through one shared datapath: averager update and trip-counter update for channel k only.
REQ-017 Averager: acc_k <= acc_k - (acc_k >> AVG_LOG2) + sample_k, acc width 12+AVG_LOG2, unsigned, never overflows; AVG_k = acc_k[11+AVG_LOG2:AVG_LOG2].
REQ-018 Over-threshold means sample strictly greater than THR_k; equality is not over-threshold.
REQ-019 Trip counter per channel, 4 bits: if EN[k] and over-threshold, increment saturating at NTRIP; otherwise clear to 0.
REQ-020 Trip bit k sets in the cycle the counter reaches NTRIP (or is already NTRIP and over-threshold again); remains set until cleared via STAT.
REQ-021 Latency: adc_valid_i at cycle t -> channel k updated on edge ending cycle t+1+k; trip_o[k]/AVG_k visible from cycle t+2+k.
REQ-022 adc_valid_i while in RUN: sample set dropped, no state change except STAT bit 8 set.
REQ-023 STAT clear and trip set for the same bit in the same cycle: set wins; same rule for overrun.
REQ-024 Writing EN bit k to 0 clears trip counter k the next cycle; does not clear trip bit k.
REQ-025 THR/EN writes take effect for any channel processed from the cycle after the write.
REQ-026 trip_o equals STAT trip bits; trip_any_o is combinational OR, no extra register stage.

Reset
REQ-027 rst_i asserted: FSM IDLE, channel index 0, all acc 0, all trip counters 0, trip_o 0, trip_any_o 0, overrun 0, EN 6'h00, THR0-5 12'hFFF, snapshots 0.
REQ-028 Reset asserted mid-RUN abandons the pass; no partial channel update survives; first adc_valid_i after release starts a clean pass.

Verification
REQ-029 EN=6'h3F, THR2=0x800, NTRIP=4; four passes with adc2_i=0x801, others 0x100 -> trip_o=6'b000100 exactly 4 cycles after fourth adc_valid_i (k=2), trip_any_o=1; no trip after only three passes.
REQ-030 THR2=0x800, adc2_i=0x800 for 10 passes -> trip_o stays 0; pattern 0x801x3, 0x7FF, 0x801x3 -> no trip (counter cleared by miss).
REQ-031 AVG_LOG2=4, constant 0x400 on ch0 from reset -> AVG0=0x040 after pass 1, monotonically rising, reaches 0x3FF or 0x400 and stays there, never exceeding 0x400.
REQ-032 Tripped ch2: write STAT=0x0004 in same cycle as re-trip set -> bit stays 1; write in quiet cycle -> bit 0, trip_any_o 0 next cycle.
REQ-033 Second adc_valid_i 3 cycles after first -> STAT bit 8 = 1, only one pass processed; write STAT=0x0100 -> bit 8 = 0.
REQ-034 Assert rst_i during RUN at k=3 -> all outputs and registers at REQ-027 values immediately; read of 0x20 returns 0x0000.

Source files
------------

// File: rtl/adc_monitor.sv
// adc_monitor: six-channel ADC averager and over-threshold trip monitor.
// One shared datapath walks channels 0..5, one per cycle, after each sample set.
module adc_monitor #(
  parameter int NTRIP    = 4,
  parameter int AVG_LOG2 = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_we_i,
  input  logic [7:0]  reg_addr_i,
  input  logic [15:0] reg_data_i,
  output logic [15:0] reg_data_o,
  input  logic        adc_valid_i,
  input  logic [11:0] adc0_i,
  input  logic [11:0] adc1_i,
  input  logic [11:0] adc2_i,
  input  logic [11:0] adc3_i,
  input  logic [11:0] adc4_i,
  input  logic [11:0] adc5_i,
  output logic [5:0]  trip_o,
  output logic        trip_any_o
);

  localparam int AW = 12 + AVG_LOG2;
  localparam logic [3:0] LP_NTRIP = 4'(NTRIP);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;

  logic [11:0]   r_snap [6];
  logic [AW-1:0] r_acc  [6];
  logic [3:0]    r_cnt  [6];
  logic [11:0]   r_thr  [6];
  logic [5:0]    r_en;
  logic [5:0]    r_trip;
  logic          r_ovr;

  logic [11:0] w_adc [6];
  assign w_adc[0] = adc0_i;
  assign w_adc[1] = adc1_i;
  assign w_adc[2] = adc2_i;
  assign w_adc[3] = adc3_i;
  assign w_adc[4] = adc4_i;
  assign w_adc[5] = adc5_i;

  logic w_start;
  logic w_overrun;
  logic w_proc;
  assign w_start   = adc_valid_i && (r_state == S_IDLE);
  assign w_overrun = adc_valid_i && (r_state == S_RUN);
  assign w_proc    = (r_state == S_RUN);

  // Only bits 11:0, 8 and 5:0 of write data are ever stored.
  logic w_unused;
  assign w_unused = ^reg_data_i[15:12];

  // FSM state and channel index register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // FSM next state: IDLE waits for a sample set, RUN walks channels 0..5
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      S_IDLE: begin
        if (adc_valid_i) begin
          w_state_nxt = S_RUN;
          w_idx_nxt   = 3'd0;
        end
      end
      S_RUN: begin
        if (r_idx == 3'd5) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 3'd0;
        end else begin
          w_idx_nxt = r_idx + 3'd1;
        end
      end
    endcase
  end

  // Register-write decode
  logic       w_wr_en;
  logic       w_wr_stat;
  logic [5:0] w_wr_thr;
  logic [5:0] w_trip_clr;
  logic       w_ovr_clr;

  always_comb begin
    w_wr_en   = reg_we_i && (reg_addr_i == 8'h16);
    w_wr_stat = reg_we_i && (reg_addr_i == 8'h17);
    w_wr_thr  = 6'h00;
    for (int k = 0; k < 6; k++) begin
      w_wr_thr[k] = reg_we_i && (reg_addr_i == 8'h10 + 8'(k));
    end
    w_trip_clr = w_wr_stat ? reg_data_i[5:0] : 6'h00;
    w_ovr_clr  = w_wr_stat && reg_data_i[8];
  end

  // Shared datapath: select channel r_idx, compute its averager and counter
  logic [11:0]   w_sample;
  logic [AW-1:0] w_acc;
  logic [AW-1:0] w_acc_nxt;
  logic [3:0]    w_cnt;
  logic [3:0]    w_cnt_nxt;
  logic [11:0]   w_thr;
  logic          w_en_k;
  logic          w_hit;
  logic          w_trip_hit;
  logic [5:0]    w_sel;
  logic [5:0]    w_trip_set;

  always_comb begin
    w_sample = 12'h000;
    w_acc    = '0;
    w_cnt    = 4'h0;
    w_thr    = 12'h000;
    w_en_k   = 1'b0;
    w_sel    = 6'h00;
    for (int k = 0; k < 6; k++) begin
      if (r_idx == 3'(k)) begin
        w_sample = r_snap[k];
        w_acc    = r_acc[k];
        w_cnt    = r_cnt[k];
        w_thr    = r_thr[k];
        w_en_k   = r_en[k];
        w_sel[k] = w_proc;
      end
    end
    w_acc_nxt = w_acc - (w_acc >> AVG_LOG2) + AW'(w_sample);
    w_hit     = w_en_k && (w_sample > w_thr);
    if (!w_hit) begin
      w_cnt_nxt = 4'h0;
    end else if (w_cnt >= LP_NTRIP) begin
      w_cnt_nxt = LP_NTRIP;
    end else begin
      w_cnt_nxt = w_cnt + 4'h1;
    end
    w_trip_hit = w_hit && (w_cnt_nxt == LP_NTRIP);
    w_trip_set = w_sel & {6{w_trip_hit}};
  end

  // Sample snapshot on pass start
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 6; k++) r_snap[k] <= 12'h000;
    end else if (w_start) begin
      for (int k = 0; k < 6; k++) r_snap[k] <= w_adc[k];
    end
  end

  // Per-channel accumulator and trip counter; EN bit cleared wipes the counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 6; k++) begin
        r_acc[k] <= '0;
        r_cnt[k] <= 4'h0;
      end
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (w_sel[k]) begin
          r_acc[k] <= w_acc_nxt;
          r_cnt[k] <= w_cnt_nxt;
        end
        if (w_wr_en && !reg_data_i[k]) begin
          r_cnt[k] <= 4'h0;
        end
      end
    end
  end

  // Threshold and enable configuration registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 6; k++) r_thr[k] <= 12'hFFF;
      r_en <= 6'h00;
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (w_wr_thr[k]) r_thr[k] <= reg_data_i[11:0];
      end
      if (w_wr_en) r_en <= reg_data_i[5:0];
    end
  end

  // Sticky status: a set in the same cycle as a clear wins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_trip <= 6'h00;
      r_ovr  <= 1'b0;
    end else begin
      r_trip <= (r_trip & ~w_trip_clr) | w_trip_set;
      r_ovr  <= (r_ovr & ~w_ovr_clr) | w_overrun;
    end
  end

  assign trip_o     = r_trip;
  assign trip_any_o = |r_trip;

  // Register read mux, purely combinational from the address
  always_comb begin
    reg_data_o = 16'h0000;
    for (int k = 0; k < 6; k++) begin
      if (reg_addr_i == 8'h10 + 8'(k)) begin
        reg_data_o = {4'h0, r_thr[k]};
      end
      if (reg_addr_i == 8'h18 + 8'(k)) begin
        reg_data_o = {4'h0, r_acc[k][AW-1:AVG_LOG2]};
      end
    end
    if (reg_addr_i == 8'h16) begin
      reg_data_o = {10'h000, r_en};
    end
    if (reg_addr_i == 8'h17) begin
      reg_data_o = {7'h00, r_ovr, 2'b00, r_trip};
    end
  end

endmodule

// File: tb/tb_adc_monitor.sv
// tb_adc_monitor: directed and randomized checks of adc_monitor
// against a pass-level behavioural model.
module tb_adc_monitor;

  localparam int L  = 4;
  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        valid = 1'b0;
  logic [11:0] adc [6];
  logic [5:0]  trip;
  logic        trip_any;

  int n_assert = 0;
  int n_fail = 0;

  int         m_acc [6];
  int         m_cnt [6];
  int         m_thr [6];
  logic [5:0] m_trip;
  logic [5:0] m_en;
  logic       m_ovr;
  int         cur_s [6];

  adc_monitor #(.NTRIP(NT), .AVG_LOG2(L)) dut (
    .clk_i(clk), .rst_i(rst),
    .reg_we_i(we), .reg_addr_i(addr),
    .reg_data_i(wdata), .reg_data_o(rdata),
    .adc_valid_i(valid),
    .adc0_i(adc[0]), .adc1_i(adc[1]), .adc2_i(adc[2]),
    .adc3_i(adc[3]), .adc4_i(adc[4]), .adc5_i(adc[5]),
    .trip_o(trip), .trip_any_o(trip_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 6; k++) begin
      m_acc[k] = 0;
      m_cnt[k] = 0;
      m_thr[k] = 'hFFF;
    end
    m_trip = 6'h00;
    m_en = 6'h00;
    m_ovr = 1'b0;
  endfunction

  function automatic void model_pass();
    for (int k = 0; k < 6; k++) begin
      m_acc[k] = m_acc[k] - m_acc[k] / (1 << L) + cur_s[k];
      if (m_en[k] && cur_s[k] > m_thr[k]) begin
        m_cnt[k] = (m_cnt[k] + 1 > NT) ? NT : m_cnt[k] + 1;
        if (m_cnt[k] == NT) m_trip[k] = 1'b1;
      end else begin
        m_cnt[k] = 0;
      end
    end
  endfunction

  function automatic void model_wr(input int a, input int d);
    if (a >= 'h10 && a <= 'h15) m_thr[a - 'h10] = d & 'hFFF;
    if (a == 'h16) begin
      m_en = d[5:0];
      for (int k = 0; k < 6; k++) if (!d[k]) m_cnt[k] = 0;
    end
    if (a == 'h17) begin
      m_trip = m_trip & ~d[5:0];
      if (d[8]) m_ovr = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    we = 1'b1;
    addr = 8'(a);
    wdata = 16'(d);
    tick();
    we = 1'b0;
    model_wr(a, d);
  endtask

  task automatic rd(input int a, output logic [15:0] d);
    addr = 8'(a);
    #1;
    d = rdata;
  endtask

  task automatic drive_set();
    for (int k = 0; k < 6; k++) adc[k] = 12'(cur_s[k]);
  endtask

  task automatic run_pass();
    drive_set();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (6) tick();
    model_pass();
  endtask

  task automatic check_all(input string tag);
    logic [15:0] d;
    chk({tag, "_trip"}, 32'(trip), 32'(m_trip));
    chk({tag, "_any"}, 32'(trip_any), 32'(|m_trip));
    rd('h17, d);
    chk({tag, "_stat"}, 32'(d), {23'd0, m_ovr, 2'b00, m_trip});
    for (int k = 0; k < 6; k++) begin
      rd('h18 + k, d);
      chk($sformatf("%s_avg%0d", tag, k), 32'(d),
          32'((m_acc[k] >> L) & 'hFFF));
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] prev;
    for (int k = 0; k < 6; k++) adc[k] = 12'h000;
    model_reset();
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check_all("reset");
    for (int k = 0; k < 6; k++) begin
      rd('h10 + k, d);
      chk($sformatf("reset_thr%0d", k), 32'(d), 32'h0FFF);
    end
    rd('h16, d);
    chk("reset_en", 32'(d), 32'h0);
    rd('h20, d);
    chk("unmapped", 32'(d), 32'h0);

    // four over-threshold passes on ch2 trip exactly on the fourth
    wr('h16, 'h3F);
    wr('h12, 'h800);
    wr('h1A, 'h123);
    rd('h1A, d);
    chk("ro_write_ignored", 32'(d), 32'h0);
    for (int k = 0; k < 6; k++) cur_s[k] = 'h100;
    cur_s[2] = 'h801;
    for (int p = 0; p < 3; p++) begin
      run_pass();
      check_all($sformatf("ntrip_p%0d", p));
    end
    drive_set();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    chk("trip_before_k2", 32'(trip), 32'h0);
    tick();
    chk("trip_at_k2", 32'(trip), 32'h04);
    chk("any_at_k2", 32'(trip_any), 32'h1);
    repeat (3) tick();
    model_pass();
    check_all("ntrip_p3");

    // STAT clear colliding with a re-trip: set wins
    drive_set();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    we = 1'b1;
    addr = 8'h17;
    wdata = 16'h0004;
    tick();
    we = 1'b0;
    chk("clr_vs_set", 32'(trip[2]), 32'h1);
    repeat (3) tick();
    model_pass();
    check_all("clr_collide");
    wr('h17, 'h0004);
    chk("clr_quiet_trip", 32'(trip), 32'h0);
    chk("clr_quiet_any", 32'(trip_any), 32'h0);

    // equality is not over-threshold; a miss resets the counter
    cur_s[2] = 'h800;
    for (int p = 0; p < 10; p++) begin
      run_pass();
      chk($sformatf("eq_p%0d", p), 32'(trip), 32'h0);
    end
    for (int p = 0; p < 7; p++) begin
      cur_s[2] = (p == 3) ? 'h7FF : 'h801;
      run_pass();
      check_all($sformatf("miss_p%0d", p));
    end
    chk("miss_no_trip", 32'(trip), 32'h0);

    // EN bit dropped clears the counter
    cur_s[2] = 'h800;
    run_pass();
    cur_s[2] = 'h801;
    run_pass();
    run_pass();
    wr('h16, 'h3B);
    wr('h16, 'h3F);
    run_pass();
    run_pass();
    check_all("en_clear");
    chk("en_clear_no_trip", 32'(trip), 32'h0);

    // overrun: second valid 3 cycles after the first is dropped
    for (int k = 0; k < 6; k++) cur_s[k] = int'($urandom_range(0, 4095));
    drive_set();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 6; k++) adc[k] = 12'($urandom);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (3) tick();
    model_pass();
    m_ovr = 1'b1;
    check_all("overrun");
    wr('h17, 'h0100);
    rd('h17, d);
    chk("overrun_clr", 32'(d[8]), 32'h0);
    run_pass();
    check_all("after_overrun");

    // randomized passes with random configuration
    for (int p = 0; p < 24; p++) begin
      if ($urandom_range(0, 1) == 1) begin
        wr('h10 + int'($urandom_range(0, 5)),
           int'($urandom_range('h600, 'hA00)));
      end
      if (p % 5 == 0) wr('h16, int'($urandom_range(0, 63)));
      if (p % 4 == 3) wr('h17, int'($urandom & 'h13F));
      for (int k = 0; k < 6; k++) cur_s[k] = int'($urandom_range(0, 4095));
      run_pass();
      check_all($sformatf("rnd_p%0d", p));
    end

    // reset in the middle of a pass at k=3
    wr('h16, 'h3F);
    wr('h10, 'h000);
    for (int k = 0; k < 6; k++) cur_s[k] = 'h100;
    for (int p = 0; p < 4; p++) run_pass();
    chk("pre_reset_trip0", 32'(trip[0]), 32'h1);
    drive_set();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("midrun_reset");
    for (int k = 0; k < 6; k++) begin
      rd('h10 + k, d);
      chk($sformatf("midrun_thr%0d", k), 32'(d), 32'h0FFF);
    end
    rd('h16, d);
    chk("midrun_en", 32'(d), 32'h0);
    rd('h20, d);
    chk("midrun_0x20", 32'(d), 32'h0);
    tick();
    rst = 1'b0;

    // averager step response from reset, constant 0x400 on ch0
    for (int k = 0; k < 6; k++) cur_s[k] = 0;
    cur_s[0] = 'h400;
    run_pass();
    check_all("avg_p1");
    rd('h18, prev);
    chk("avg_first", 32'(prev), 32'h040);
    for (int p = 0; p < 150; p++) begin
      run_pass();
      rd('h18, d);
      chk($sformatf("avg_model_p%0d", p), 32'(d),
          32'((m_acc[0] >> L) & 'hFFF));
      chk($sformatf("avg_bound_p%0d", p),
          32'((d >= prev) && (d <= 16'h400)), 32'h1);
      prev = d;
    end
    chk("avg_settled", 32'((prev == 16'h3FF) || (prev == 16'h400)), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
